// File: rtl/pixel_write_queue_pkg.sv
// Shared graphics constants and the pixel record stored in the write queue.
// Reused by the map/link/enemy draw code; ON/OFF are the 1-bit level names.
package pixel_write_queue_pkg;

  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;
  localparam int FB_ADDR_W  = 17;
  localparam int COLOUR_W   = 6;
  localparam int X_W        = 9;
  localparam int Y_W        = 8;
  localparam int FIFO_DEPTH = 16;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // One queued pixel: raw coordinates plus colour (2b R, 2b G, 2b B).
  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  localparam int PIXEL_W = $bits(pixel_t);

endpackage

// File: rtl/pixel_write_queue_fifo.sv
// Synchronous FIFO holding pixel records, with occupancy count and flags.
// The caller only asserts wr_en when there is room (or a read happens in the
// same cycle) and only asserts rd_en when not empty. DEPTH is a power of two
// so the pointers wrap naturally.
module pixel_write_queue_fifo
  import pixel_write_queue_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = PIXEL_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage array: written at the tail, no reset needed.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous read and write leave count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/pixel_write_queue.sv
// Pixel write queue: clips datapath pixel writes to the visible screen,
// buffers them in a FIFO and drains them to the framebuffer write port
// through a single output register, converting (x,y) to y*SCREEN_W + x.
// Optional build macro PWQ_STATS_EN adds saturating transfer/clip counters.
//
// Framebuffer handshake: mem_we is the valid. A write transfers on a rising
// edge where mem_we and mem_ready are both high. While mem_we=1 and
// mem_ready=0, mem_we/mem_addr/mem_data hold stable. mem_ready is ignored
// while mem_we=0.
module pixel_write_queue
  import pixel_write_queue_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int SCREEN_W = pixel_write_queue_pkg::SCREEN_W,
  parameter int SCREEN_H = pixel_write_queue_pkg::SCREEN_H,
  parameter int ADDR_W   = FB_ADDR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [X_W-1:0]      x_position,
  input  logic [Y_W-1:0]      y_position,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                VGA_enable,
  input  logic                clear_overflow,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic                drained,
  output logic                overflow
`ifdef PWQ_STATS_EN
  ,
  output logic [15:0]         stat_written,
  output logic [15:0]         stat_clipped
`endif
);

  localparam int                CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_W);

  pixel_t              wr_pixel;
  pixel_t              head;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    count_d;
  logic                fifo_full;
  logic                fifo_empty;

  logic                in_range;
  logic                strobe_clipped;
  logic                load;
  logic                pop;
  logic                push;
  logic                drop;

  logic                mem_we_q,   mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [COLOUR_W-1:0] mem_data_q, mem_data_d;
  logic                overflow_q;
  logic                drained_q;

  // Clip: only strobes landing on the visible screen enter the queue.
  assign in_range       = VGA_enable && (int'(x_position) < SCREEN_W)
                                     && (int'(y_position) < SCREEN_H);
  assign strobe_clipped = VGA_enable && !in_range;

  // Output register refills when empty or when its write completes this edge.
  assign load = !mem_we_q || mem_ready;
  assign pop  = load && !fifo_empty;
  // A full FIFO still takes a pixel when the head leaves in the same cycle.
  assign push = in_range && (!fifo_full || pop);
  assign drop = in_range && !push;

  assign wr_pixel = '{x: x_position, y: y_position, colour: colour};

  pixel_write_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PIXEL_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (wr_pixel),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next output-stage contents and next FIFO occupancy.
  always_comb begin
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    count_d    = fifo_count;
    if (load) begin
      mem_we_d = pop;
      if (pop) begin
        mem_addr_d = ADDR_W'(head.y) * ROW_STRIDE + ADDR_W'(head.x);
        mem_data_d = head.colour;
      end
    end
    if (push && !pop) begin
      count_d = fifo_count + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = fifo_count - CNT_W'(1);
    end
  end

  // Output register; drained tracks the state being entered so it never lags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_we_q   <= OFF;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      drained_q  <= ON;
    end else begin
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      drained_q  <= (count_d == '0) && !mem_we_d;
    end
  end

  // Sticky overflow: a drop in the same cycle beats a clear request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q <= OFF;
    end else if (drop) begin
      overflow_q <= ON;
    end else if (clear_overflow) begin
      overflow_q <= OFF;
    end
  end

`ifdef PWQ_STATS_EN
  logic [15:0] stat_written_q;
  logic [15:0] stat_clipped_q;

  // Saturating counters of completed writes and clipped strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_written_q <= '0;
      stat_clipped_q <= '0;
    end else if (clear_overflow) begin
      stat_written_q <= '0;
      stat_clipped_q <= '0;
    end else begin
      if (mem_we_q && mem_ready && (stat_written_q != 16'hFFFF)) begin
        stat_written_q <= stat_written_q + 16'd1;
      end
      if (strobe_clipped && (stat_clipped_q != 16'hFFFF)) begin
        stat_clipped_q <= stat_clipped_q + 16'd1;
      end
    end
  end

  assign stat_written = stat_written_q;
  assign stat_clipped = stat_clipped_q;
`endif

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign drained  = drained_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Bench for pixel_write_queue: vector table of single pixels plus hand-written
// backpressure, overflow, full-throughput and mid-run reset sequences. Every
// framebuffer write is checked against an in-order expected queue.
module tb_pixel_write_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  x_position = '0;
  logic [7:0]  y_position = '0;
  logic [5:0]  colour = '0;
  logic        VGA_enable = 1'b0;
  logic        clear_overflow = 1'b0;
  logic [16:0] mem_addr;
  logic [5:0]  mem_data;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic        drained;
  logic        overflow;
`ifdef PWQ_STATS_EN
  logic [15:0] stat_written;
  logic [15:0] stat_clipped;
`endif

  pixel_write_queue dut (
    .clock          (clock),
    .reset          (reset),
    .x_position     (x_position),
    .y_position     (y_position),
    .colour         (colour),
    .VGA_enable     (VGA_enable),
    .clear_overflow (clear_overflow),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .mem_ready      (mem_ready),
    .drained        (drained),
    .overflow       (overflow)
`ifdef PWQ_STATS_EN
    ,
    .stat_written   (stat_written),
    .stat_clipped   (stat_clipped)
`endif
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state: {addr, data} expected in write order
  logic [22:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: a write seen with mem_we && mem_ready completes on the next edge
  always @(negedge clock) begin
    if (!reset && mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'({mem_addr, mem_data}), 32'h7FFF_FFFF);
      end else begin
        check("write_order", 32'({mem_addr, mem_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    VGA_enable     = 1'b0;
    clear_overflow = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_pixel(input int x, input int y, input int c, input bit keep);
    VGA_enable = 1'b1;
    x_position = 9'(x);
    y_position = 8'(y);
    colour     = 6'(c);
    if (keep) exp_q.push_back({17'(y * 320 + x), 6'(c)});
    tick();
    VGA_enable = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(name, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  // Single pixel after reset: one cycle to mem_we, then back to idle
  task automatic single_pixel(input string tag);
    mem_ready = 1'b1;
    drive_pixel(5, 2, 'h3F, 1'b1);
    check({tag, "_we_latency"}, 32'(mem_we), 32'd0);
    check({tag, "_busy"}, 32'(drained), 32'd0);
    tick();
    check({tag, "_we"}, 32'(mem_we), 32'd1);
    check({tag, "_addr"}, 32'(mem_addr), 32'd645);
    check({tag, "_data"}, 32'(mem_data), 32'h3F);
    tick();
    check({tag, "_we_off"}, 32'(mem_we), 32'd0);
    check({tag, "_drained"}, 32'(drained), 32'd1);
  endtask

  typedef struct {
    int          x;
    int          y;
    int          c;
    bit          keep;
    logic [16:0] addr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{x: 5,   y: 2,   c: 'h3F, keep: 1'b1, addr: 17'd645};
    vecs[1] = '{x: 0,   y: 0,   c: 'h01, keep: 1'b1, addr: 17'd0};
    vecs[2] = '{x: 319, y: 239, c: 'h2A, keep: 1'b1, addr: 17'd76799};
    vecs[3] = '{x: 320, y: 0,   c: 'h15, keep: 1'b0, addr: 17'd0};
    vecs[4] = '{x: 319, y: 0,   c: 'h3E, keep: 1'b1, addr: 17'd319};
    vecs[5] = '{x: 0,   y: 239, c: 'h07, keep: 1'b1, addr: 17'd76480};
    vecs[6] = '{x: 0,   y: 240, c: 'h11, keep: 1'b0, addr: 17'd0};
    vecs[7] = '{x: 511, y: 255, c: 'h3C, keep: 1'b0, addr: 17'd0};
    vecs[8] = '{x: 100, y: 100, c: 'h22, keep: 1'b1, addr: 17'd32100};
    vecs[9] = '{x: 1,   y: 1,   c: 'h00, keep: 1'b1, addr: 17'd321};

    // Reset state
    do_reset();
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drained", 32'(drained), 32'd1);

    // Single pixel
    single_pixel("t1");
`ifdef PWQ_STATS_EN
    check("t1_stat_written", 32'(stat_written), 32'd1);
`endif

    // Vector table, one strobe per cycle at full rate
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      VGA_enable = 1'b1;
      x_position = 9'(vecs[i].x);
      y_position = 8'(vecs[i].y);
      colour     = 6'(vecs[i].c);
      if (vecs[i].keep) exp_q.push_back({vecs[i].addr, 6'(vecs[i].c)});
      tick();
      check("vec_overflow", 32'(overflow), 32'd0);
    end
    VGA_enable = 1'b0;
    wait_drain("vec_drain", 20);
    check("vec_drained", 32'(drained), 32'd1);
`ifdef PWQ_STATS_EN
    check("vec_stat_clipped", 32'(stat_clipped), 32'd3);
    check("vec_stat_written", 32'(stat_written), 32'd8);
`endif

    // Clipping only: nothing queued, no overflow
    do_reset();
    mem_ready = 1'b1;
    drive_pixel(320, 0, 'h0A, 1'b0);
    check("clip_drained_a", 32'(drained), 32'd1);
    drive_pixel(0, 240, 'h0B, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("clip_we", 32'(mem_we), 32'd0);
      check("clip_drained", 32'(drained), 32'd1);
      tick();
    end
    check("clip_overflow", 32'(overflow), 32'd0);
`ifdef PWQ_STATS_EN
    check("clip_stat_clipped", 32'(stat_clipped), 32'd2);
`endif

    // Backpressure: outputs hold while stalled, then drain in order
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_pixel(10 + i * 7, 50 + i, i + 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("stall_we", 32'(mem_we), 32'd1);
      check("stall_hold", 32'({mem_addr, mem_data}), 32'(exp_q[0]));
      tick();
    end
    mem_ready = 1'b1;
    wait_drain("stall_drain", 20);
    check("stall_drained", 32'(drained), 32'd1);

    // Overflow: 18 pushes into 17 slots, set beats clear, clear, then drain
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 18; i++) drive_pixel(i, 10, i, i < 17);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_head", 32'({mem_addr, mem_data}), 32'({17'd3200, 6'd0}));
    clear_overflow = 1'b1;
    drive_pixel(100, 100, 5, 1'b0);
    check("ovf_set_beats_clear", 32'(overflow), 32'd1);
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_not_drained", 32'(drained), 32'd0);
    mem_ready = 1'b1;
    wait_drain("ovf_drain", 40);
    check("ovf_drained", 32'(drained), 32'd1);
    check("ovf_stays_clear", 32'(overflow), 32'd0);

    // Full queue with push and pop every cycle: no drops
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 17; i++) drive_pixel(i, 20, i + 3, 1'b1);
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) drive_pixel(100 + i, 30, i + 9, 1'b1);
    check("full_overflow", 32'(overflow), 32'd0);
    check("full_busy", 32'(drained), 32'd0);
    wait_drain("full_drain", 40);
    check("full_drained", 32'(drained), 32'd1);
    check("full_overflow_end", 32'(overflow), 32'd0);

    // Reset mid-run with 8 queued: outputs clear without a clock edge
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive_pixel(40 + i, 60, i, 1'b1);
    tick();
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_we", 32'(mem_we), 32'd0);
    check("async_rst_drained", 32'(drained), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    single_pixel("t6");
    tick();
    check("t6_final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
